// File: rtl/board_state_scanner_if.sv
// Bus between the game-control side and the board state scanner: write port,
// registered read port and scan status/result.
interface board_state_scanner_if #(
  parameter int ADDR_W = 4
);
  logic              clear;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        data;
  logic [ADDR_W-1:0] rd_addr;
  logic [1:0]        rd_data;
  logic              busy;
  logic              done;
  logic              write_drop;
  logic [1:0]        state_final;

  modport master (
    output clear, we, addr, data, rd_addr,
    input  rd_data, busy, done, write_drop, state_final
  );

  modport slave (
    input  clear, we, addr, data, rd_addr,
    output rd_data, busy, done, write_drop, state_final
  );
endinterface

// File: rtl/board_state_scanner.sv
// N x N macro-board cell memory with a one-line-per-cycle win scanner that
// re-resolves the game result after every accepted write.
module board_state_scanner #(
  parameter int N      = 3,
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  board_state_scanner_if.slave bus
);

  localparam int CELLS  = N * N;
  localparam int LINES  = 2 * N + 2;
  localparam int CIDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int LIDX_W = $clog2(LINES);
  localparam logic [ADDR_W:0]   CELLS_A   = (ADDR_W + 1)'(CELLS);
  localparam logic [LIDX_W-1:0] LAST_LINE = LIDX_W'(LINES - 1);

  typedef enum logic {
    S_IDLE,
    S_SCAN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cell [CELLS];
  logic [LIDX_W-1:0] r_line_idx;
  logic              r_p1;
  logic              r_p2;
  logic [1:0]        r_final;
  logic [1:0]        r_rd_data;
  logic              r_done;
  logic              r_drop;

  logic              w_addr_ok;
  logic              w_rd_ok;
  logic              w_accept;
  logic              w_drop;
  logic              w_last;
  logic              w_all1;
  logic              w_all2;
  logic              w_full;
  logic [CIDX_W-1:0] w_ci;
  logic [1:0]        w_rd_val;

  // Line numbering: rows, then columns, then main and anti diagonal.
  function automatic logic [CIDX_W-1:0] cell_of_line(input int l, input int k);
    int c;
    if (l < N)           c = l * N + k;
    else if (l < 2 * N)  c = (l - N) + k * N;
    else if (l == 2 * N) c = k * (N + 1);
    else                 c = (k + 1) * (N - 1);
    return CIDX_W'(c);
  endfunction

  function automatic logic [1:0] resolve(input logic p1, input logic p2, input logic full);
    if (p1 && p2) return 2'b11;
    if (p1)       return 2'b01;
    if (p2)       return 2'b10;
    if (full)     return 2'b11;
    return 2'b00;
  endfunction

  assign w_addr_ok = ({1'b0, bus.addr} < CELLS_A);
  assign w_rd_ok   = ({1'b0, bus.rd_addr} < CELLS_A);
  assign w_rd_val  = w_rd_ok ? r_cell[bus.rd_addr[CIDX_W-1:0]] : 2'b00;
  assign w_last    = (r_state == S_SCAN) && (r_line_idx == LAST_LINE);

  always_comb begin
    w_all1 = 1'b1;
    w_all2 = 1'b1;
    w_full = 1'b1;
    w_ci   = '0;
    for (int k = 0; k < N; k++) begin
      w_ci = cell_of_line(int'(r_line_idx), k);
      if (r_cell[w_ci] != 2'b01) w_all1 = 1'b0;
      if (r_cell[w_ci] != 2'b10) w_all2 = 1'b0;
    end
    for (int i = 0; i < CELLS; i++) begin
      if (r_cell[CIDX_W'(i)] == 2'b00) w_full = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_drop   = 1'b0;
    if (bus.we && !bus.clear) begin
      if (r_state == S_SCAN || !w_addr_ok) w_drop   = 1'b1;
      else                                 w_accept = 1'b1;
    end
    unique case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SCAN;
      S_SCAN:  if (w_last)   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (bus.clear) w_next = S_IDLE;
  end

  // Board, scan accumulators and result; clear behaves like reset on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cell     <= '{default: 2'b00};
      r_line_idx <= '0;
      r_p1       <= 1'b0;
      r_p2       <= 1'b0;
      r_final    <= 2'b00;
      r_rd_data  <= 2'b00;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
    end else if (bus.clear) begin
      r_cell     <= '{default: 2'b00};
      r_line_idx <= '0;
      r_p1       <= 1'b0;
      r_p2       <= 1'b0;
      r_final    <= 2'b00;
      r_rd_data  <= 2'b00;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_drop    <= w_drop;
      r_rd_data <= w_rd_val;
      if (w_accept) begin
        r_cell[bus.addr[CIDX_W-1:0]] <= bus.data;
        r_line_idx <= '0;
        r_p1       <= 1'b0;
        r_p2       <= 1'b0;
      end else if (r_state == S_SCAN) begin
        r_p1       <= r_p1 | w_all1;
        r_p2       <= r_p2 | w_all2;
        r_line_idx <= r_line_idx + 1'b1;
        // The last line's hits are folded in directly, not via r_p1/r_p2.
        if (w_last) begin
          r_final <= resolve(r_p1 | w_all1, r_p2 | w_all2, w_full);
          r_done  <= 1'b1;
        end
      end
    end
  end

  assign bus.busy        = (r_state == S_SCAN);
  assign bus.done        = r_done;
  assign bus.write_drop  = r_drop;
  assign bus.state_final = r_final;
  assign bus.rd_data     = r_rd_data;

endmodule
